// File: rtl/ram_arbiter_if.sv
// Bus bundle for the two-master RAM arbiter: both master request ports plus the shared RAM port.
// The master modport is the arbiter's view, because it masters the RAM port. The slave modport is the environment's view.
interface ram_arbiter_if;
    logic [31:0] m0_address;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_wsel;
    logic        m0_valid;
    logic [31:0] m0_rdata;
    logic        m0_ready;
    logic        m0_error;

    logic [31:0] m1_address;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_wsel;
    logic        m1_valid;
    logic [31:0] m1_rdata;
    logic        m1_ready;
    logic        m1_error;

    logic [31:0] ram_address;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_wsel;
    logic        ram_valid;
    logic [31:0] ram_rdata;
    logic        ram_ready;
    logic        ram_error;

    modport master (
        input  m0_address, m0_wdata, m0_wsel, m0_valid,
        output m0_rdata, m0_ready, m0_error,
        input  m1_address, m1_wdata, m1_wsel, m1_valid,
        output m1_rdata, m1_ready, m1_error,
        output ram_address, ram_wdata, ram_wsel, ram_valid,
        input  ram_rdata, ram_ready, ram_error
    );

    modport slave (
        output m0_address, m0_wdata, m0_wsel, m0_valid,
        input  m0_rdata, m0_ready, m0_error,
        output m1_address, m1_wdata, m1_wsel, m1_valid,
        input  m1_rdata, m1_ready, m1_error,
        input  ram_address, ram_wdata, ram_wsel, ram_valid,
        output ram_rdata, ram_ready, ram_error
    );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that lets two masters share one RAM slave. Every access passes
// through IDLE, so ram_valid drops for at least one cycle between accesses.
module ram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.master bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    logic [0:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic [7:0] wait_q, wait_d;

    logic busy;
    logic timeout;
    logic done;
    logic done_err;
    logic grant_sel;

    assign busy    = (state_q == S_BUSY);
    // A ready in the timeout cycle takes priority, so that cycle completes normally.
    assign timeout = busy && !bus.ram_ready && (wait_q == WAIT_LAST);
    assign done    = busy && (bus.ram_ready || timeout);
    assign done_err = bus.ram_ready ? bus.ram_error : 1'b1;

    always_comb begin
        grant_sel = 1'b0;
        if (bus.m0_valid && bus.m1_valid) begin
            grant_sel = ~last_q;
        end else if (bus.m1_valid) begin
            grant_sel = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    state_d = S_BUSY;
                    grant_d = grant_sel;
                    wait_d  = '0;
                end
            end
            S_BUSY: begin
                if (done) begin
                    state_d = S_IDLE;
                    last_d  = grant_q;
                end else if (wait_q != '1) begin
                    wait_d = wait_q + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
        end
    end

    // The payload comes from the grant register, so a master that drops valid cannot disturb the access.
    assign bus.ram_valid   = busy;
    assign bus.ram_address = grant_q ? bus.m1_address : bus.m0_address;
    assign bus.ram_wdata   = grant_q ? bus.m1_wdata   : bus.m0_wdata;
    assign bus.ram_wsel    = grant_q ? bus.m1_wsel    : bus.m0_wsel;

    assign bus.m0_ready = done && !grant_q;
    assign bus.m1_ready = done &&  grant_q;
    assign bus.m0_error = bus.m0_ready && done_err;
    assign bus.m1_error = bus.m1_ready && done_err;
    assign bus.m0_rdata = (busy && !grant_q) ? bus.ram_rdata : '0;
    assign bus.m1_rdata = (busy &&  grant_q) ? bus.ram_rdata : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with TIMEOUT=4. It models both masters and a RAM slave whose latency can be changed.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    int unsigned slave_lat = 1;
    logic        slave_err = 1'b0;
    logic        stray = 1'b0;
    int unsigned scyc;
    logic [31:0] mem [0:255];

    ram_arbiter_if bus ();

    ram_arbiter #(.TIMEOUT(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // RAM slave: ready is a registered pulse slave_lat edges after ram_valid is seen. A latency of 0 means ready never comes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ram_ready <= 1'b0;
            bus.ram_error <= 1'b0;
            bus.ram_rdata <= '0;
            scyc <= 0;
            for (int i = 0; i < 256; i++) mem[i] <= {24'h5A5A5A, 8'(i)};
            mem[64] <= 32'hDEADBEEF;
            mem[8]  <= 32'hAABBCCDD;
        end else if (bus.ram_valid && !bus.ram_ready) begin
            if (slave_lat != 0 && scyc + 1 == slave_lat) begin
                bus.ram_ready <= 1'b1;
                bus.ram_error <= slave_err;
                bus.ram_rdata <= mem[bus.ram_address[9:2]];
                for (int b = 0; b < 4; b++)
                    if (bus.ram_wsel[b])
                        mem[bus.ram_address[9:2]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
                scyc <= 0;
            end else begin
                bus.ram_ready <= 1'b0;
                scyc <= scyc + 1;
            end
        end else begin
            bus.ram_ready <= stray;
            bus.ram_error <= 1'b0;
            scyc <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int m, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (m == 0) begin
            bus.m0_valid = v; bus.m0_address = a; bus.m0_wdata = d; bus.m0_wsel = s;
        end else begin
            bus.m1_valid = v; bus.m1_address = a; bus.m1_wdata = d; bus.m1_wsel = s;
        end
    endtask

    task automatic access(input string tag, input int m, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s, input int nbusy,
                          input logic chk_rd, input logic [31:0] exp_rd, input logic exp_err);
        logic rdy_m, rdy_o, err_m, err_o;
        logic [31:0] rd_m, rd_o;
        @(negedge clk);
        drive(m, 1'b1, a, d, s);
        for (int c = 1; c <= nbusy; c++) begin
            @(negedge clk);
            rdy_m = (m == 0) ? bus.m0_ready : bus.m1_ready;
            rdy_o = (m == 0) ? bus.m1_ready : bus.m0_ready;
            err_m = (m == 0) ? bus.m0_error : bus.m1_error;
            err_o = (m == 0) ? bus.m1_error : bus.m0_error;
            rd_m  = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
            rd_o  = (m == 0) ? bus.m1_rdata : bus.m0_rdata;
            check({tag, ".ram_valid"}, 32'(bus.ram_valid), 32'd1);
            check({tag, ".ram_address"}, bus.ram_address, a);
            check({tag, ".ram_wdata"}, bus.ram_wdata, d);
            check({tag, ".ram_wsel"}, 32'(bus.ram_wsel), 32'(s));
            check({tag, ".other_ready"}, 32'(rdy_o), 32'd0);
            if (c < nbusy) begin
                check({tag, ".early_ready"}, 32'(rdy_m), 32'd0);
            end else begin
                check({tag, ".ready"}, 32'(rdy_m), 32'd1);
                check({tag, ".error"}, 32'(err_m), 32'(exp_err));
                check({tag, ".other_error"}, 32'(err_o), 32'd0);
                check({tag, ".other_rdata"}, rd_o, 32'h0);
                if (chk_rd) check({tag, ".rdata"}, rd_m, exp_rd);
                drive(m, 1'b0, a, d, s);
            end
        end
        @(negedge clk);
        check({tag, ".idle_valid"}, 32'(bus.ram_valid), 32'd0);
        check({tag, ".idle_ready"}, 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
    endtask

    initial begin
        logic g;
        rst_n = 1'b0;
        drive(0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, '0, '0, '0);

        repeat (2) @(negedge clk);
        check("rst.ram_valid", 32'(bus.ram_valid), 32'd0);
        check("rst.ready", 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
        check("rst.error", 32'({bus.m0_error, bus.m1_error}), 32'd0);

        // Release reset with both masters already requesting. The first rising edge must grant m0.
        rst_n = 1'b1;
        drive(0, 1'b1, 32'h0, '0, '0);
        drive(1, 1'b1, 32'h4, '0, '0);
        for (int i = 0; i < 4; i++) begin
            g = (i % 2 == 1);
            @(negedge clk);
            check($sformatf("rr%0d.busy", i), 32'(bus.ram_valid), 32'd1);
            check($sformatf("rr%0d.address", i), bus.ram_address, g ? 32'h4 : 32'h0);
            check($sformatf("rr%0d.early", i), 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
            @(negedge clk);
            check($sformatf("rr%0d.ready", i), 32'({bus.m1_ready, bus.m0_ready}), g ? 32'd2 : 32'd1);
            check($sformatf("rr%0d.rdata", i), g ? bus.m1_rdata : bus.m0_rdata,
                  g ? 32'h5A5A5A01 : 32'h5A5A5A00);
            if (i == 3) begin
                drive(0, 1'b0, '0, '0, '0);
                drive(1, 1'b0, '0, '0, '0);
            end
            @(negedge clk);
            check($sformatf("rr%0d.gap", i), 32'(bus.ram_valid), 32'd0);
            check($sformatf("rr%0d.gap_ready", i), 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
        end

        access("rd100", 0, 32'h100, 32'h0, 4'h0, 2, 1'b1, 32'hDEADBEEF, 1'b0);
        access("wr20", 1, 32'h20, 32'h11223344, 4'b0011, 2, 1'b0, 32'h0, 1'b0);
        access("rb20", 0, 32'h20, 32'h0, 4'h0, 2, 1'b1, 32'hAABB3344, 1'b0);

        slave_lat = 2;
        access("lat2", 1, 32'h10, 32'h0, 4'h0, 3, 1'b1, 32'h5A5A5A04, 1'b0);
        slave_lat = 0;
        access("tmo", 0, 32'h0, 32'h0, 4'h0, 4, 1'b0, 32'h0, 1'b1);
        slave_lat = 3;
        access("tmo_ready", 0, 32'h14, 32'h0, 4'h0, 4, 1'b1, 32'h5A5A5A05, 1'b0);
        slave_lat = 1;
        slave_err = 1'b1;
        access("slv_err", 1, 32'h18, 32'h0, 4'h0, 2, 1'b1, 32'h5A5A5A06, 1'b1);
        slave_err = 1'b0;

        // Master drops valid after the grant. The access must still complete.
        @(negedge clk);
        drive(1, 1'b1, 32'h30, '0, '0);
        @(negedge clk);
        check("drop.busy", 32'(bus.ram_valid), 32'd1);
        drive(1, 1'b0, 32'h30, '0, '0);
        @(negedge clk);
        check("drop.ready", 32'(bus.m1_ready), 32'd1);
        check("drop.rdata", bus.m1_rdata, 32'h5A5A5A0C);
        @(negedge clk);
        check("drop.idle", 32'(bus.ram_valid), 32'd0);
        @(negedge clk);
        check("drop.no_regrant", 32'(bus.ram_valid), 32'd0);

        // A stray ram_ready while IDLE must be ignored.
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        check("stray.ready", 32'({bus.m0_ready, bus.m1_ready}), 32'd0);
        check("stray.error", 32'({bus.m0_error, bus.m1_error}), 32'd0);
        check("stray.valid", 32'(bus.ram_valid), 32'd0);
        access("after_stray", 0, 32'h8, 32'h0, 4'h0, 2, 1'b1, 32'h5A5A5A02, 1'b0);

        // Reset in the middle of an access: ram_valid falls without a clock edge and no response ever follows.
        slave_lat = 0;
        @(negedge clk);
        drive(0, 1'b1, 32'h40, '0, '0);
        @(negedge clk);
        check("arst.busy", 32'(bus.ram_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst.valid_async", 32'(bus.ram_valid), 32'd0);
        check("arst.ready_async", 32'({bus.m0_ready, bus.m0_error}), 32'd0);
        drive(0, 1'b0, 32'h40, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        slave_lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("arst.quiet%0d", i),
                  32'({bus.ram_valid, bus.m0_ready, bus.m1_ready}), 32'd0);
        end
        access("arst.next", 0, 32'h100, 32'h0, 4'h0, 2, 1'b1, 32'hDEADBEEF, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
